// File: rtl/stopwatch_button_ctrl.sv
// stopwatch_button_ctrl: synchronizes and debounces the start/stop and clear buttons,
// toggles the run level on each start/stop press and stretches every clear event so
// that clr_n stays low for CLEAR_HOLD clk cycles.
// Optional feature macro: LONG_PRESS_CLEAR_EN (a long btn_run hold also fires a clear).
module stopwatch_button_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
   parameter int unsigned CLEAR_HOLD        = 100_000,
   parameter int unsigned LONG_PRESS_CYCLES = 100_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_run,
   input  logic btn_clr,
   output logic run,
   output logic clr_n,
   output logic run_pulse,
   output logic clr_pulse
);

   localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int unsigned HoldW = $clog2(CLEAR_HOLD) + 1;
   localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HoldW-1:0] HoldLast = HoldW'(CLEAR_HOLD - 1);

   typedef enum logic [0:0] {StIdle, StHold} clr_state_e;

   // Bit 0 carries btn_run, bit 1 carries btn_clr.
   logic [1:0]          sync1_q, sync1_d, sync2_q, sync2_d;
   logic [1:0]          db_state_q, db_state_d, db_prev_q, db_prev_d;
   logic [1:0][DbW-1:0] db_cnt_q, db_cnt_d;
   logic [1:0]          press;

   clr_state_e       state_q, state_d;
   logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
   logic             run_q, run_d, clr_n_q, clr_n_d;
   logic             run_pulse_q, run_pulse_d, clr_pulse_q, clr_pulse_d;
   logic             lp_fire;

   // Synchronizer shift and debounce counters for both buttons.
   always_comb begin
      sync1_d    = {btn_clr, btn_run};
      sync2_d    = sync1_q;
      db_prev_d  = db_state_q;
      db_state_d = db_state_q;
      db_cnt_d   = '0;
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] != db_state_q[i]) begin
            if (db_cnt_q[i] == DbLast) begin
               db_state_d[i] = sync2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
            end
         end
      end
   end

   // A press is a rising edge of the debounced level; releases are ignored.
   always_comb begin
      press = db_state_q & ~db_prev_q;
   end

`ifdef LONG_PRESS_CLEAR_EN
   localparam int unsigned LpW = $clog2(LONG_PRESS_CYCLES) + 1;
   localparam logic [LpW-1:0] LpLast = LpW'(LONG_PRESS_CYCLES - 1);

   logic [LpW-1:0] lp_cnt_q, lp_cnt_d;
   logic           lp_done_q, lp_done_d;

   // Time a held run button; one clear per hold, deferred until the clear FSM is idle.
   always_comb begin
      lp_cnt_d  = lp_cnt_q;
      lp_done_d = lp_done_q;
      lp_fire   = 1'b0;
      if (!db_state_q[0]) begin
         lp_cnt_d  = '0;
         lp_done_d = 1'b0;
      end else if (!lp_done_q) begin
         if (lp_cnt_q == LpLast) begin
            if (state_q == StIdle) begin
               lp_fire   = 1'b1;
               lp_done_d = 1'b1;
               lp_cnt_d  = '0;
            end
         end else begin
            lp_cnt_d = lp_cnt_q + LpW'(1);
         end
      end
   end

   // Long-press counter state.
   always_ff @(posedge clk) begin
      if (rst) begin
         lp_cnt_q  <= '0;
         lp_done_q <= 1'b0;
      end else begin
         lp_cnt_q  <= lp_cnt_d;
         lp_done_q <= lp_done_d;
      end
   end
`else
   // Parameter kept so both builds share one interface.
   logic unused_lp_cycles;
   assign unused_lp_cycles = ^LONG_PRESS_CYCLES;

   always_comb begin
      lp_fire = 1'b0;
   end
`endif

   // Clear FSM and run toggle; a clear event beats a run press on the same edge.
   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      run_d       = run_q;
      clr_n_d     = clr_n_q;
      run_pulse_d = 1'b0;
      clr_pulse_d = 1'b0;
      case (state_q)
         StIdle: begin
            if (press[1] || lp_fire) begin
               state_d     = StHold;
               hold_cnt_d  = '0;
               clr_pulse_d = 1'b1;
               clr_n_d     = 1'b0;
               run_d       = 1'b0;
            end else if (press[0]) begin
               run_pulse_d = 1'b1;
               run_d       = ~run_q;
            end
         end
         StHold: begin
            if (hold_cnt_q == HoldLast) begin
               state_d    = StIdle;
               hold_cnt_d = '0;
               clr_n_d    = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q + HoldW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         db_state_q  <= '0;
         db_prev_q   <= '0;
         db_cnt_q    <= '0;
         state_q     <= StIdle;
         hold_cnt_q  <= '0;
         run_q       <= 1'b0;
         clr_n_q     <= 1'b1;
         run_pulse_q <= 1'b0;
         clr_pulse_q <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         db_state_q  <= db_state_d;
         db_prev_q   <= db_prev_d;
         db_cnt_q    <= db_cnt_d;
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         run_q       <= run_d;
         clr_n_q     <= clr_n_d;
         run_pulse_q <= run_pulse_d;
         clr_pulse_q <= clr_pulse_d;
      end
   end

   assign run       = run_q;
   assign clr_n     = clr_n_q;
   assign run_pulse = run_pulse_q;
   assign clr_pulse = clr_pulse_q;

endmodule

// File: tb/tb_stopwatch_button_ctrl.sv
// Testbench for stopwatch_button_ctrl: directed scenarios with fixed expectations plus a
// randomized run against a timeline model. Honours LONG_PRESS_CLEAR_EN like the design.
module tb_stopwatch_button_ctrl;

   localparam int D  = 4;
   localparam int CH = 8;
   localparam int LP = 20;
   localparam int NH = 4096;
`ifdef LONG_PRESS_CLEAR_EN
   localparam bit LpEn = 1'b1;
`else
   localparam bit LpEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_run = 1'b0;
   logic btn_clr = 1'b0;
   logic run, clr_n, run_pulse, clr_pulse;

   int checks = 0;
   int errors = 0;

   // Timeline model: raw samples and debounced levels indexed by edge number since reset.
   logic s_hist  [2][NH];
   logic db_hist [2][NH];
   int   mcyc;
   int   m_last [2];
   int   m_cs;
   int   m_rise_run;
   logic m_lp_fired;
   logic m_run, m_clrn, m_rp, m_cp;

   stopwatch_button_ctrl #(
      .DEBOUNCE_CYCLES  (D),
      .CLEAR_HOLD       (CH),
      .LONG_PRESS_CYCLES(LP)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_run  (btn_run),
      .btn_clr  (btn_clr),
      .run      (run),
      .clr_n    (clr_n),
      .run_pulse(run_pulse),
      .clr_pulse(clr_pulse)
   );

   always #5 clk = ~clk;

   function automatic logic s_at(input int b, input int m);
      if (m < 0) return 1'b0;
      return s_hist[b][m];
   endfunction

   function automatic logic db_at(input int b, input int m);
      if (m < 0) return 1'b0;
      return db_hist[b][m];
   endfunction

   function automatic void model_reset();
      mcyc       = 0;
      m_last[0]  = -1;
      m_last[1]  = -1;
      m_cs       = -1000;
      m_rise_run = -1000;
      m_lp_fired = 1'b0;
      m_run      = 1'b0;
      m_clrn     = 1'b1;
      m_rp       = 1'b0;
      m_cp       = 1'b0;
   endfunction

   // Edge n: a level is accepted once the synchronized sample (raw delayed by two edges)
   // has disagreed with it on D consecutive edges since the last accepted change.
   function automatic void model_step(input logic r, input logic c);
      int   n;
      logic press_run, press_clr, in_hold, lp_fire, dbp, all_diff;
      n = mcyc;
      s_hist[0][n] = r;
      s_hist[1][n] = c;
      m_rp = 1'b0;
      m_cp = 1'b0;
      press_run = db_at(0, n - 1) && !db_at(0, n - 2);
      press_clr = db_at(1, n - 1) && !db_at(1, n - 2);
      in_hold   = (n > m_cs) && (n <= m_cs + CH);
      lp_fire   = 1'b0;
      if (LpEn) begin
         if (!db_at(0, n - 1)) m_lp_fired = 1'b0;
         else if (!m_lp_fired && n >= m_rise_run + LP && !in_hold) begin
            lp_fire    = 1'b1;
            m_lp_fired = 1'b1;
         end
      end
      if (!in_hold) begin
         if (press_clr || lp_fire) begin
            m_cs   = n;
            m_cp   = 1'b1;
            m_run  = 1'b0;
            m_clrn = 1'b0;
         end else if (press_run) begin
            m_rp  = 1'b1;
            m_run = !m_run;
         end
      end
      if (n == m_cs + CH) m_clrn = 1'b1;
      for (int b = 0; b < 2; b++) begin
         dbp = db_at(b, n - 1);
         db_hist[b][n] = dbp;
         if (n - D + 1 > m_last[b]) begin
            all_diff = 1'b1;
            for (int m = n - D + 1; m <= n; m++) if (s_at(b, m - 2) == dbp) all_diff = 1'b0;
            if (all_diff) begin
               db_hist[b][n] = !dbp;
               m_last[b] = n;
               if (b == 0 && !dbp) m_rise_run = n;
            end
         end
      end
      mcyc++;
   endfunction

   task automatic tick(input logic r, input logic c);
      btn_run = r;
      btn_clr = c;
      @(posedge clk);
      model_step(r, c);
      #1;
   endtask

   task automatic apply_reset(input int cycles);
      rst = 1'b1;
      btn_run = 1'b0;
      btn_clr = 1'b0;
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
      model_reset();
      rst = 1'b0;
   endtask

   task automatic press_run_clean();
      for (int k = 0; k < 18; k++) tick(k < 8, 1'b0);
   endtask

   task automatic test_reset();
      int changed;
      apply_reset(2);
      checks++; if (run !== 1'b0) begin errors++; $display("FAIL reset_run: got %b want 0", run); end
      checks++; if (clr_n !== 1'b1) begin errors++; $display("FAIL reset_clr_n: got %b want 1", clr_n); end
      checks++; if (run_pulse !== 1'b0) begin errors++; $display("FAIL reset_run_pulse: got %b want 0", run_pulse); end
      checks++; if (clr_pulse !== 1'b0) begin errors++; $display("FAIL reset_clr_pulse: got %b want 0", clr_pulse); end
      changed = 0;
      for (int k = 0; k < 10; k++) begin
         tick(1'b0, 1'b0);
         if (run !== 1'b0 || clr_n !== 1'b1 || run_pulse !== 1'b0 || clr_pulse !== 1'b0) changed++;
      end
      checks++; if (changed !== 0) begin errors++; $display("FAIL reset_idle: got %0d changed cycles want 0", changed); end
   endtask

   task automatic test_clean_press();
      int   pulses, first_idx;
      logic exp_run;
      for (int rep = 0; rep < 2; rep++) begin
         pulses = 0;
         first_idx = -1;
         for (int k = 0; k < 20; k++) begin
            tick(k < 10, 1'b0);
            if (run_pulse === 1'b1) begin
               pulses++;
               if (first_idx < 0) first_idx = k;
            end
         end
         exp_run = (rep == 0);
         checks++; if (pulses !== 1) begin errors++; $display("FAIL clean_pulses: got %0d want 1", pulses); end
         checks++; if (first_idx !== 6) begin errors++; $display("FAIL clean_latency: got %0d want 6", first_idx); end
         checks++; if (run !== exp_run) begin errors++; $display("FAIL clean_run: got %b want %b", run, exp_run); end
      end
   endtask

   task automatic test_bounce();
      int   pulses, first_idx;
      logic pat [7];
      logic run0;
      pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      run0 = run;
      pulses = 0;
      for (int k = 0; k < 17; k++) begin
         tick((k < 7) ? pat[k] : 1'b0, 1'b0);
         if (run_pulse === 1'b1) pulses++;
      end
      checks++; if (pulses !== 0) begin errors++; $display("FAIL bounce_pulses: got %0d want 0", pulses); end
      checks++; if (run !== run0) begin errors++; $display("FAIL bounce_run: got %b want %b", run, run0); end
      pulses = 0;
      first_idx = -1;
      for (int k = 0; k < 16; k++) begin
         tick(k < 6, 1'b0);
         if (run_pulse === 1'b1) begin
            pulses++;
            if (first_idx < 0) first_idx = k;
         end
      end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL bounce_stable_pulses: got %0d want 1", pulses); end
      checks++; if (first_idx !== 6) begin errors++; $display("FAIL bounce_stable_latency: got %0d want 6", first_idx); end
      checks++; if (run !== !run0) begin errors++; $display("FAIL bounce_stable_run: got %b want %b", run, !run0); end
   endtask

   task automatic test_clear();
      int   cp_cnt, cp_idx, rp_cnt, low_cnt, run_hi;
      logic run_at_cp;
      apply_reset(2);
      press_run_clean();
      checks++; if (run !== 1'b1) begin errors++; $display("FAIL clear_setup_run: got %b want 1", run); end
      cp_cnt = 0; cp_idx = -1; rp_cnt = 0; low_cnt = 0; run_hi = 0; run_at_cp = 1'b1;
      for (int k = 0; k < 24; k++) begin
         tick(k >= 1 && k <= 6, k < 6);
         if (clr_pulse === 1'b1) begin
            cp_cnt++;
            cp_idx = k;
            run_at_cp = run;
         end
         if (run_pulse === 1'b1) rp_cnt++;
         if (clr_n === 1'b0) low_cnt++;
         if (k >= 6 && run !== 1'b0) run_hi++;
      end
      checks++; if (cp_cnt !== 1) begin errors++; $display("FAIL clear_pulses: got %0d want 1", cp_cnt); end
      checks++; if (cp_idx !== 6) begin errors++; $display("FAIL clear_latency: got %0d want 6", cp_idx); end
      checks++; if (run_at_cp !== 1'b0) begin errors++; $display("FAIL clear_run_same_edge: got %b want 0", run_at_cp); end
      checks++; if (low_cnt !== CH) begin errors++; $display("FAIL clear_low_len: got %0d want %0d", low_cnt, CH); end
      checks++; if (rp_cnt !== 0) begin errors++; $display("FAIL clear_run_ignored: got %0d pulses want 0", rp_cnt); end
      checks++; if (run_hi !== 0) begin errors++; $display("FAIL clear_run_stays_low: got %0d high cycles want 0", run_hi); end
   endtask

   task automatic test_same_edge();
      int cp_cnt, rp_cnt, low_cnt, cp_idx;
      apply_reset(2);
      press_run_clean();
      cp_cnt = 0; rp_cnt = 0; low_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         tick(k < 6, k < 6);
         if (clr_pulse === 1'b1) cp_cnt++;
         if (run_pulse === 1'b1) rp_cnt++;
         if (clr_n === 1'b0) low_cnt++;
      end
      checks++; if (rp_cnt !== 0) begin errors++; $display("FAIL same_edge_run_pulse: got %0d want 0", rp_cnt); end
      checks++; if (cp_cnt !== 1) begin errors++; $display("FAIL same_edge_clr_pulse: got %0d want 1", cp_cnt); end
      checks++; if (low_cnt !== CH) begin errors++; $display("FAIL same_edge_low_len: got %0d want %0d", low_cnt, CH); end
      checks++; if (run !== 1'b0) begin errors++; $display("FAIL same_edge_run: got %b want 0", run); end
      // Enter HOLD again, then reset on its third cycle.
      cp_idx = -1;
      for (int k = 0; k < 9; k++) begin
         tick(1'b0, k < 6);
         if (clr_pulse === 1'b1) cp_idx = k;
      end
      checks++; if (cp_idx !== 6) begin errors++; $display("FAIL midhold_clr_pulse: got %0d want 6", cp_idx); end
      checks++; if (clr_n !== 1'b0) begin errors++; $display("FAIL midhold_pre_rst: got %b want 0", clr_n); end
      rst = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
      checks++; if (clr_n !== 1'b1) begin errors++; $display("FAIL midhold_rst_clr_n: got %b want 1", clr_n); end
      checks++; if (clr_pulse !== 1'b0 || run_pulse !== 1'b0 || run !== 1'b0) begin
         errors++; $display("FAIL midhold_rst_outs: got %b%b%b want 000", clr_pulse, run_pulse, run);
      end
      rst = 1'b0;
      low_cnt = 0;
      for (int k = 0; k < 12; k++) begin
         tick(1'b0, 1'b0);
         if (clr_n !== 1'b1 || clr_pulse !== 1'b0) low_cnt++;
      end
      checks++; if (low_cnt !== 0) begin errors++; $display("FAIL midhold_idle_after: got %0d bad cycles want 0", low_cnt); end
   endtask

   task automatic test_long_press();
      int   rp_cnt, cp_cnt, cp_idx, low_cnt, exp_cp, exp_idx, exp_low;
      logic run_mid, exp_end;
      apply_reset(2);
      rp_cnt = 0; cp_cnt = 0; cp_idx = -1; low_cnt = 0; run_mid = 1'b0;
      for (int k = 0; k < 62; k++) begin
         tick(k < 50, 1'b0);
         if (run_pulse === 1'b1) rp_cnt++;
         if (clr_pulse === 1'b1) begin
            cp_cnt++;
            cp_idx = k;
         end
         if (clr_n === 1'b0) low_cnt++;
         if (k == 10) run_mid = run;
      end
      exp_cp  = LpEn ? 1 : 0;
      exp_idx = LpEn ? 25 : -1;
      exp_low = LpEn ? CH : 0;
      exp_end = !LpEn;
      checks++; if (rp_cnt !== 1) begin errors++; $display("FAIL long_run_pulse: got %0d want 1", rp_cnt); end
      checks++; if (run_mid !== 1'b1) begin errors++; $display("FAIL long_run_mid: got %b want 1", run_mid); end
      checks++; if (cp_cnt !== exp_cp) begin errors++; $display("FAIL long_clr_pulses: got %0d want %0d", cp_cnt, exp_cp); end
      checks++; if (cp_idx !== exp_idx) begin errors++; $display("FAIL long_clr_edge: got %0d want %0d", cp_idx, exp_idx); end
      checks++; if (low_cnt !== exp_low) begin errors++; $display("FAIL long_low_len: got %0d want %0d", low_cnt, exp_low); end
      checks++; if (run !== exp_end) begin errors++; $display("FAIL long_run_end: got %b want %b", run, exp_end); end
   endtask

   task automatic test_random();
      logic lvl_r, lvl_c;
      int   rem_r, rem_c;
      apply_reset(2);
      lvl_r = 1'b0; lvl_c = 1'b0; rem_r = 0; rem_c = 0;
      for (int k = 0; k < 2000; k++) begin
         if (rem_r == 0) begin
            lvl_r = 1'($urandom_range(0, 1));
            rem_r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                               : int'($urandom_range(4, 30));
         end
         if (rem_c == 0) begin
            lvl_c = ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
            rem_c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                               : int'($urandom_range(4, 30));
         end
         rem_r--;
         rem_c--;
         tick(lvl_r, lvl_c);
         checks++; if (run !== m_run) begin errors++; $display("FAIL rand_run @%0d: got %b want %b", k, run, m_run); end
         checks++; if (clr_n !== m_clrn) begin errors++; $display("FAIL rand_clr_n @%0d: got %b want %b", k, clr_n, m_clrn); end
         checks++; if (run_pulse !== m_rp) begin errors++; $display("FAIL rand_run_pulse @%0d: got %b want %b", k, run_pulse, m_rp); end
         checks++; if (clr_pulse !== m_cp) begin errors++; $display("FAIL rand_clr_pulse @%0d: got %b want %b", k, clr_pulse, m_cp); end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_clean_press();
      test_bounce();
      test_clear();
      test_same_edge();
      test_long_press();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
